ascii_stream_ctrl: RTL

//  Arbitrates two ASCII byte sources (src0 = UART RX, src1 = banner/message ROM) onto the

---
 rtl/ascii_stream_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ascii_stream_ctrl.sv
// Two-source ASCII arbiter for the 8x8 character buffer write port.
// Translates LF/TAB/BS into legal sequences and mirrors the cursor column.
module ascii_stream_ctrl #(
   parameter int p_num_cols  = 32,
   parameter int p_tab_width = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    src0_ascii,
   input  logic                          src0_val,
   output logic                          src0_rdy,
   input  logic [7:0]                    src1_ascii,
   input  logic                          src1_val,
   output logic                          src1_rdy,
   output logic [7:0]                    ascii,
   output logic                          ascii_val,
   output logic [$clog2(p_num_cols)-1:0] col,
   output logic                          busy
);

   localparam int CW = $clog2(p_num_cols);
   localparam logic [CW:0]   COLS_W   = (CW+1)'(p_num_cols);
   localparam logic [CW:0]   TAB_W    = (CW+1)'(p_tab_width);
   localparam logic [CW-1:0] TAB_MASK = CW'(p_tab_width - 1);
   localparam logic [CW-1:0] ONE_C    = CW'(1);
   localparam logic [CW:0]   ONE_P    = (CW+1)'(1);

   typedef enum logic {S_IDLE, S_PAD} state_t;

   state_t        state_q, state_d;
   logic [CW:0]   pad_cnt_q, pad_cnt_d;
   logic [CW-1:0] col_d;
   logic [7:0]    ascii_d;
   logic          ascii_val_d;
   logic          rr_last_q, rr_last_d;

   logic          grant0, grant1, accept;
   logic [7:0]    acc_byte;
   logic [CW:0]   lf_len, tab_len, pad_len;
   logic          start_pad;

   // rr_last=1 means source 1 was served last, so source 0 wins a tie
   always_comb begin
      grant0   = src0_val & (~src1_val | rr_last_q);
      grant1   = src1_val & (~src0_val | ~rr_last_q);
      src0_rdy = grant0 & (state_q == S_IDLE) & ~rst;
      src1_rdy = grant1 & (state_q == S_IDLE) & ~rst;
      accept   = src0_rdy | src1_rdy;
      acc_byte = src1_rdy ? src1_ascii : src0_ascii;
      busy     = (state_q == S_PAD);
      lf_len   = COLS_W - {1'b0, col};
      tab_len  = TAB_W - {1'b0, (col & TAB_MASK)};
   end

   always_comb begin
      state_d     = state_q;
      pad_cnt_d   = pad_cnt_q;
      col_d       = col;
      ascii_d     = ascii;
      ascii_val_d = 1'b0;
      rr_last_d   = rr_last_q;
      pad_len     = '0;
      start_pad   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               rr_last_d = src1_rdy;
               if (acc_byte >= 8'h20 && acc_byte <= 8'h7E) begin
                  ascii_d     = acc_byte;
                  ascii_val_d = 1'b1;
                  col_d       = col + ONE_C;
               end else if (acc_byte == 8'h1B) begin
                  ascii_d     = 8'h1B;
                  ascii_val_d = 1'b1;
                  col_d       = '0;
               end else if (acc_byte == 8'h08 || acc_byte == 8'h7F || acc_byte == 8'hFF) begin
                  // The buffer cannot back up across a row, so BS at column 0 is dropped
                  if (col != '0) begin
                     ascii_d     = 8'hFF;
                     ascii_val_d = 1'b1;
                     col_d       = col - ONE_C;
                  end
               end else if (acc_byte == 8'h0A) begin
                  pad_len   = lf_len;
                  start_pad = 1'b1;
               end else if (acc_byte == 8'h09) begin
                  pad_len   = tab_len;
                  start_pad = 1'b1;
               end
            end
            // First pad space goes out right away; the rest come from PAD
            if (start_pad) begin
               ascii_d     = 8'h20;
               ascii_val_d = 1'b1;
               col_d       = col + ONE_C;
               pad_cnt_d   = pad_len - ONE_P;
               if (pad_len != ONE_P) begin
                  state_d = S_PAD;
               end
            end
         end
         S_PAD: begin
            ascii_d     = 8'h20;
            ascii_val_d = 1'b1;
            col_d       = col + ONE_C;
            pad_cnt_d   = pad_cnt_q - ONE_P;
            if (pad_cnt_q == ONE_P) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pad_cnt_q <= '0;
         col       <= '0;
         ascii     <= 8'h00;
         ascii_val <= 1'b0;
         rr_last_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         pad_cnt_q <= pad_cnt_d;
         col       <= col_d;
         ascii     <= ascii_d;
         ascii_val <= ascii_val_d;
         rr_last_q <= rr_last_d;
      end
   end

endmodule
